bip_debug_unit: RTL and testbench
=================================

# bip_debug_unit

Run-control and debug-dump stage for the accumulator processor. It pulses the processor clear, enables execution, and counts clock cycles until the control block reports a halt. It then snapshots PC, accumulator and cycle count, and streams a 10-byte frame to the downstream UART transmitter over a valid/ready byte handshake. It sits between the processor top level (consumes its `halt`, PC and accumulator) and the UART TX.

## Interface
Parameters:
- `AB`, 11, program-counter width (must be ≤ 16)
- `DB`, 16, accumulator width (must be ≤ 16)
- `CW`, 32, cycle-counter width (fixed at 32 for the frame format)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new run; level-sampled
- `halt`  in  1  halt decoded by the control block (opcode 0)
- `pc`  in  AB  current program address
- `acc`  in  DB  current accumulator value
- `cpu_en`  out  1  processor clock-enable
- `cpu_clear`  out  1  one-cycle processor clear pulse
- `tx_data`  out  8  frame byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  UART TX accepts byte
- `busy`  out  1  high in every state except IDLE and DONE

## Operation
- States: IDLE, CLR, RUN, SEND, DONE.
- IDLE/DONE + `start`=1 → CLR. `start` is ignored in CLR, RUN and SEND.
- CLR: `cpu_clear`=1 for exactly one cycle, counter ← 0. Next state RUN.
- RUN: `cpu_en`=1. Counter increments every cycle and saturates at 0xFFFF_FFFF (no wrap).
- RUN + `halt`=1: latch `pc`, `acc` and the counter value including the halt cycle (count+1, saturating). Byte index ← 0. Next state SEND. `cpu_en` drops in the same edge.
- `halt` is ignored outside RUN.
- SEND: the frame is big-endian, 10 bytes:
  - 0xA5
  - PC[15:8], PC[7:0], with `pc` zero-extended to 16 bits
  - ACC[15:8], ACC[7:0], with `acc` zero-extended to 16 bits
  - CNT[31:24], CNT[23:16], CNT[15:8], CNT[7:0]
  - checksum = XOR of bytes 1..8 (header excluded)
- Byte transfer happens when `tx_valid` and `tx_ready` are both high on a rising edge. The index then advances.
- After byte 9 transfers, state → DONE. Snapshot registers hold their values until the next CLR.
- DONE: `cpu_en`=0. The processor stays frozen.
- Reset values: state IDLE; `cpu_en`, `cpu_clear`, `tx_valid`, `busy` = 0; `tx_data` = 0x00; counter, snapshots and index = 0.

## Timing
- `start` sampled at edge k → `cpu_clear` high during cycle k+1 → `cpu_en` high from cycle k+2.
- First RUN cycle has count 1. A halt on the first RUN cycle reports CNT=1.
- `halt` sampled at edge h → `tx_valid`=1 with the 0xA5 header from cycle h+1.
- Handshake rules:
  - `tx_valid` stays high and `tx_data` stays stable until the transfer.
  - `tx_valid` never depends combinationally on `tx_ready`.
  - With `tx_ready` held at 1, the frame takes 10 cycles, back-to-back.
- `tx_valid` drops in the cycle after the final transfer.
- `tx_ready` high while `tx_valid`=0 has no effect.
- Reset during SEND: `tx_valid` drops asynchronously and the partial frame is abandoned. No resume.
- Reset during RUN: `cpu_en` drops asynchronously and the counter is lost.

## Structure
- Shared package `bip_dbg_pkg` holds:
  - the state enum
  - `DBG_HDR` = 8'hA5
  - `DBG_FRAME_LEN` = 10
  - `DBG_CW` = 32
- Sub-module `sat_counter` (width parameter; inputs clear and enable; output count; saturates at all-ones).
- The byte mux and checksum are combinational over the snapshot registers and the index. The checksum is computed from the snapshot, not accumulated per byte.

## Test plan
- Reset, then `start` for 1 cycle; `halt` on the 7th RUN cycle with pc=0x005, acc=0x0003; `tx_ready`=1 → bytes A5 00 05 00 03 00 00 00 07 01, one per cycle; then DONE with `cpu_en`=0.
- Same run with `tx_ready` toggling 1-0-0-1 → each byte held stable while not ready; the same 10 bytes arrive in order; no duplicates or skips.
- Halt on the first RUN cycle, pc=0x7FF, acc=0xFFFF → frame A5 07 FF FF FF 00 00 00 01; checksum byte = 07^FF^FF^FF^01 = F9.
- Force the counter to 0xFFFF_FFFE, then run 5 more cycles before halt → CNT bytes FF FF FF FF (saturated).
- Assert `start` and a spurious `halt` during SEND → both ignored; frame unaffected. `start` in DONE → `cpu_clear` pulse, count restarts at 1.
- Deassert `rst_n` mid-SEND after byte 3 → `tx_valid`, `busy` and `cpu_en` are 0 immediately; state IDLE; no further bytes.

Source files
------------

// File: rtl/bip_debug_unit_pkg.sv
// Shared types and constants for the run-control / debug-dump stage:
// FSM states, frame constants and the frame byte mux with its checksum.
package bip_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } dbg_state_e;

   localparam logic [7:0] DBG_HDR       = 8'hA5;
   localparam int         DBG_FRAME_LEN = 10;
   localparam int         DBG_CW        = 32;

   // Big-endian frame: header, PC, ACC, CNT, then XOR of bytes 1..8.
   // The checksum comes straight from the snapshot so any index can be muxed.
   function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                             input logic [15:0] pc16,
                                             input logic [15:0] acc16,
                                             input logic [31:0] cnt);
      logic [7:0] b;
      case (idx)
         4'd0:    b = DBG_HDR;
         4'd1:    b = pc16[15:8];
         4'd2:    b = pc16[7:0];
         4'd3:    b = acc16[15:8];
         4'd4:    b = acc16[7:0];
         4'd5:    b = cnt[31:24];
         4'd6:    b = cnt[23:16];
         4'd7:    b = cnt[15:8];
         4'd8:    b = cnt[7:0];
         4'd9:    b = pc16[15:8] ^ pc16[7:0] ^ acc16[15:8] ^ acc16[7:0] ^
                      cnt[31:24] ^ cnt[23:16] ^ cnt[15:8] ^ cnt[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bip_debug_unit_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !(&count_q)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/bip_debug_unit.sv
// Run-control and debug-dump stage: clears and runs the processor, counts
// cycles until halt, then streams a 10-byte snapshot frame over valid/ready.
module bip_debug_unit
   import bip_dbg_pkg::*;
#(
   parameter int AB = 11,
   parameter int DB = 16,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          halt,
   input  logic [AB-1:0] pc,
   input  logic [DB-1:0] acc,
   output logic          cpu_en,
   output logic          cpu_clear,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          busy
);

   // Byte handshake: a byte moves on a rising edge with tx_valid && tx_ready.
   // tx_valid is a pure function of state, so it never looks at tx_ready, and
   // tx_data only changes when the index advances after a transfer.

   dbg_state_e    state_q, state_d;
   logic [15:0]   pc_snap_q, pc_snap_d;
   logic [15:0]   acc_snap_q, acc_snap_d;
   logic [CW-1:0] cnt_snap_q, cnt_snap_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cycle_cnt;
   logic [CW-1:0] cnt_with_halt;

   sat_counter #(.W(CW)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q == ST_CLR),
      .enable (state_q == ST_RUN),
      .count  (cycle_cnt)
   );

   // The halt cycle itself is counted, so the reported value is one ahead.
   assign cnt_with_halt = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CW'(1);

   always_comb begin
      state_d    = state_q;
      pc_snap_d  = pc_snap_q;
      acc_snap_d = acc_snap_q;
      cnt_snap_d = cnt_snap_q;
      idx_d      = idx_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_CLR;
         end
         ST_CLR: begin
            pc_snap_d  = '0;
            acc_snap_d = '0;
            cnt_snap_d = '0;
            idx_d      = '0;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            if (halt) begin
               pc_snap_d  = 16'(pc);
               acc_snap_d = 16'(acc);
               cnt_snap_d = cnt_with_halt;
               idx_d      = '0;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (idx_q == 4'(DBG_FRAME_LEN - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_snap_q  <= '0;
         acc_snap_q <= '0;
         cnt_snap_q <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_snap_q  <= pc_snap_d;
         acc_snap_q <= acc_snap_d;
         cnt_snap_q <= cnt_snap_d;
         idx_q      <= idx_d;
      end
   end

   assign cpu_clear = (state_q == ST_CLR);
   assign cpu_en    = (state_q == ST_RUN);
   assign tx_valid  = (state_q == ST_SEND);
   assign busy      = (state_q == ST_CLR) || (state_q == ST_RUN) || (state_q == ST_SEND);
   assign tx_data   = tx_valid ? frame_byte(idx_q, pc_snap_q, acc_snap_q, 32'(cnt_snap_q))
                               : 8'h00;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: full runs, stalled handshakes, counter
// saturation, ignored start/halt during SEND and reset in the middle of a frame.
module tb_bip_debug_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        halt;
   logic [10:0] pc;
   logic [15:0] acc;
   logic        cpu_en;
   logic        cpu_clear;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   int n_vec;
   int n_err;

   bip_debug_unit #(.AB(11), .DB(16), .CW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .halt      (halt),
      .pc        (pc),
      .acc       (acc),
      .cpu_en    (cpu_en),
      .cpu_clear (cpu_clear),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the first SEND cycle.
   task automatic do_run(input int n_run, input logic [10:0] pc_v, input logic [15:0] acc_v,
                         input int force_at);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("clr_pulse", {31'd0, cpu_clear}, 32'd1);
      check_eq("clr_en_low", {31'd0, cpu_en}, 32'd0);
      check_eq("clr_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      for (int i = 1; i <= n_run; i++) begin
         check_eq("run_en", {31'd0, cpu_en}, 32'd1);
         check_eq("run_clr_low", {31'd0, cpu_clear}, 32'd0);
         if (i == force_at) dut.u_cnt.count_q = 32'hFFFF_FFFE;
         if (i == n_run) begin
            halt = 1'b1;
            pc   = pc_v;
            acc  = acc_v;
         end
         @(negedge clk);
      end
      halt = 1'b0;
      pc   = 11'h000;
      acc  = 16'h0000;
   endtask

   // mode 0: ready held high; 1: ready pattern 1-0-0-1; 2: ready high with
   // spurious start/halt during the first bytes. abort_after > 0 stops early.
   task automatic recv_frame(input logic [79:0] exp_frame, input int mode, input int abort_after);
      int          idx;
      int          cyc;
      logic        rdy;
      logic [79:0] sh;
      idx = 0;
      cyc = 0;
      while (idx < 10 && cyc < 100 && !(abort_after > 0 && idx == abort_after)) begin
         sh = exp_frame >> (8 * (9 - idx));
         check_eq("send_valid", {31'd0, tx_valid}, 32'd1);
         check_eq($sformatf("byte%0d", idx), {24'd0, tx_data}, {24'd0, sh[7:0]});
         check_eq("send_en_low", {31'd0, cpu_en}, 32'd0);
         if (mode == 1) rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else           rdy = 1'b1;
         tx_ready = rdy;
         if (mode == 2 && idx < 5) begin
            start = 1'b1;
            halt  = 1'b1;
         end else begin
            start = 1'b0;
            halt  = 1'b0;
         end
         @(negedge clk);
         if (rdy) idx++;
         cyc++;
      end
      tx_ready = 1'b0;
      start    = 1'b0;
      halt     = 1'b0;
      if (cyc >= 100) check_eq("frame_timeout", 32'd0, 32'd1);
      if (idx == 10) begin
         if (mode != 1) check_eq("frame_cycles", cyc, 32'd10);
         else           check_eq("frame_cycles", cyc, 32'd20);
         check_eq("done_valid", {31'd0, tx_valid}, 32'd0);
         check_eq("done_busy", {31'd0, busy}, 32'd0);
         check_eq("done_en", {31'd0, cpu_en}, 32'd0);
         check_eq("done_data", {24'd0, tx_data}, 32'd0);
         @(negedge clk);
         check_eq("done_idle_valid", {31'd0, tx_valid}, 32'd0);
         check_eq("done_frozen_en", {31'd0, cpu_en}, 32'd0);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      halt     = 1'b0;
      pc       = 11'h000;
      acc      = 16'h0000;
      tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("rst_data", {24'd0, tx_data}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_en", {31'd0, cpu_en}, 32'd0);
      check_eq("rst_clr", {31'd0, cpu_clear}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      check_eq("idle_halt_ignored", {31'd0, busy}, 32'd0);
      halt = 1'b0;

      // Halt on RUN cycle 7, ready always high.
      do_run(7, 11'h005, 16'h0003, 0);
      recv_frame(80'hA5_00_05_00_03_00_00_00_07_01, 0, 0);

      // Same run with a stalling receiver; started from DONE.
      do_run(7, 11'h005, 16'h0003, 0);
      recv_frame(80'hA5_00_05_00_03_00_00_00_07_01, 1, 0);

      // Spurious start and halt while sending.
      do_run(3, 11'h0AB, 16'h1234, 0);
      recv_frame(80'hA5_00_AB_12_34_00_00_00_03_8E, 2, 0);

      // Halt on the first RUN cycle with all-ones PC/ACC; count restarts at 1.
      do_run(1, 11'h7FF, 16'hFFFF, 0);
      recv_frame(80'hA5_07_FF_FF_FF_00_00_00_01_F9, 0, 0);

      // Counter pushed near the top, five more cycles, then halt.
      do_run(7, 11'h123, 16'hBEEF, 2);
      recv_frame(80'hA5_01_23_BE_EF_FF_FF_FF_FF_73, 0, 0);

      // Reset after three bytes have gone out.
      do_run(4, 11'h001, 16'h0002, 0);
      recv_frame(80'hA5_00_01_00_02_00_00_00_04_07, 0, 3);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("arst_busy", {31'd0, busy}, 32'd0);
      check_eq("arst_en", {31'd0, cpu_en}, 32'd0);
      check_eq("arst_data", {24'd0, tx_data}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("post_rst_valid", {31'd0, tx_valid}, 32'd0);
         check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
      end
      tx_ready = 1'b0;

      // Fresh run after reset recovers normally.
      do_run(2, 11'h001, 16'h0002, 0);
      recv_frame(80'hA5_00_01_00_02_00_00_00_02_01, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
